// File: rtl/vlc_pkg.sv
// Shared constants for the VLC table walkers: per-table ROM roots, leaf flag position, FSM encoding.
// Latency: none (declarations only).
// Backpressure: n/a.
package vlc_pkg;

  // Root addresses of the trees in the shared coefficient/VLC table ROM.
  localparam logic [9:0] TABLE_B0_START = 10'h000;
  localparam logic [9:0] TABLE_B1_START = 10'h100;
  localparam logic [9:0] TABLE_B2_START = 10'h200;
  localparam logic [9:0] TABLE_B3_START = 10'h300;

  // The leaf flag is always the top bit of a tree entry.
  function automatic int leaf_pos(input int node_w);
    return node_w - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } vlc_state_e;

endpackage

// File: rtl/vlc_table_walker_if.sv
// Bundles the walker's bitstream, ROM and result signals; master = walker, slave = its environment.
// Latency: none (wiring only).
// Backpressure: results are held by the walker until Ack_I; bit consumption is signalled by Shift_En_O.
interface vlc_table_walker_if #(
  parameter int ADDR_W = 10,
  parameter int NODE_W = 8,
  parameter int SEL_W  = 2,
  parameter int LEN_W  = 5
);
  logic                  Start_I;
  logic [SEL_W-1:0]      Table_Sel_I;
  logic                  Data_In_I;
  logic                  Data_Valid_I;
  logic                  Shift_En_O;
  logic                  Table_En_O;
  logic [ADDR_W-1:0]     Table_Addr_O;
  logic [2*NODE_W-1:0]   Table_Data_I;
  logic                  Valid_O;
  logic [NODE_W-2:0]     Symbol_O;
  logic [LEN_W-1:0]      Length_O;
  logic                  Error_O;
  logic                  Ack_I;
  logic                  Busy_O;

  modport master (
    input  Start_I, Table_Sel_I, Data_In_I, Data_Valid_I, Table_Data_I, Ack_I,
    output Shift_En_O, Table_En_O, Table_Addr_O, Valid_O, Symbol_O, Length_O, Error_O, Busy_O
  );

  modport slave (
    output Start_I, Table_Sel_I, Data_In_I, Data_Valid_I, Table_Data_I, Ack_I,
    input  Shift_En_O, Table_En_O, Table_Addr_O, Valid_O, Symbol_O, Length_O, Error_O, Busy_O
  );
endinterface

// File: rtl/vlc_entry_sel.sv
// Picks the tree entry for the current bit, flags leaves and forms the next node's ROM address.
// Latency: combinational.
// Backpressure: none; the caller decides whether the result is used this cycle.
module vlc_entry_sel
  import vlc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int NODE_W = 8
) (
  input  logic                bit_i,
  input  logic [2*NODE_W-1:0] word_i,
  input  logic [ADDR_W-1:0]   base_i,
  output logic                leaf_o,
  output logic [NODE_W-2:0]   payload_o,
  output logic [ADDR_W-1:0]   next_addr_o
);
  localparam int LEAF  = leaf_pos(NODE_W);
  localparam int SUM_W = (ADDR_W > NODE_W - 1) ? ADDR_W : NODE_W - 1;

  logic [NODE_W-1:0] entry;
  logic [SUM_W-1:0]  sum;

  // Upper half of the ROM word belongs to bit 1; the index is added to the table root and wraps.
  always_comb begin
    entry       = bit_i ? word_i[2*NODE_W-1:NODE_W] : word_i[NODE_W-1:0];
    leaf_o      = entry[LEAF];
    payload_o   = entry[NODE_W-2:0];
    sum         = SUM_W'(base_i) + SUM_W'(entry[NODE_W-2:0]);
    next_addr_o = sum[ADDR_W-1:0];
  end
endmodule

// File: rtl/vlc_table_walker.sv
// Walks a binary VLC tree one bitstream bit per cycle and returns the symbol and its code length.
// Latency: an N-bit code gives Valid_O N+1 cycles after Start_I; each Data_Valid_I-low cycle adds one.
// Backpressure: Symbol/Length (or Error) held until Ack_I; Start_I restarts a walk, ignored in DONE/ERR without Ack_I.
module vlc_table_walker
  import vlc_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int NODE_W     = 8,
  parameter int NUM_TABLES = 4,
  parameter int SEL_W      = 2,
  parameter logic [NUM_TABLES*ADDR_W-1:0] TABLE_BASE = {NUM_TABLES{ADDR_W'(0)}},
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5
) (
  input logic               clock,
  input logic               resetn,
  vlc_table_walker_if.master bus
);

  vlc_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  depth_q, depth_d;
  logic [NODE_W-2:0] sym_q, sym_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic              shift_en;
  logic              table_en;
  logic              restart;
  logic [LEN_W-1:0]  depth_inc;
  logic [ADDR_W-1:0] cur_root;
  logic [ADDR_W-1:0] new_root;
  logic              leaf;
  logic [NODE_W-2:0] payload;
  logic [ADDR_W-1:0] next_addr;

  function automatic logic [ADDR_W-1:0] root_of(input logic [SEL_W-1:0] sel);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_TABLES; k++) begin
      if (int'(sel) == k) r = TABLE_BASE[k*ADDR_W +: ADDR_W];
    end
    return r;
  endfunction

  // Node indices are relative to the root of the table latched at Start_I.
  always_comb begin
    cur_root = root_of(sel_q);
    new_root = root_of(bus.Table_Sel_I);
  end

  vlc_entry_sel #(
    .ADDR_W (ADDR_W),
    .NODE_W (NODE_W)
  ) u_entry_sel (
    .bit_i       (bus.Data_In_I),
    .word_i      (bus.Table_Data_I),
    .base_i      (cur_root),
    .leaf_o      (leaf),
    .payload_o   (payload),
    .next_addr_o (next_addr)
  );

  // Next-state and ROM/shift control; a restart overrides whatever the walk would have done.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    depth_d   = depth_q;
    sym_d     = sym_q;
    len_d     = len_q;
    shift_en  = 1'b0;
    table_en  = 1'b0;
    restart   = 1'b0;
    depth_inc = depth_q + 1'b1;

    case (state_q)
      ST_IDLE: restart = bus.Start_I;
      ST_WALK: begin
        if (bus.Start_I) begin
          restart = 1'b1;
        end else if (bus.Data_Valid_I) begin
          shift_en = 1'b1;
          if (leaf) begin
            sym_d   = payload;
            len_d   = depth_inc;
            state_d = ST_DONE;
          end else if (depth_inc == LEN_W'(MAX_LEN)) begin
            state_d = ST_ERR;
          end else begin
            addr_d   = next_addr;
            depth_d  = depth_inc;
            table_en = 1'b1;
          end
        end else begin
          // Stall: re-read the current node so the ROM output still matches it next cycle.
          table_en = 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        if (bus.Ack_I) begin
          restart = bus.Start_I;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      sel_d    = bus.Table_Sel_I;
      addr_d   = new_root;
      depth_d  = '0;
      table_en = 1'b1;
      state_d  = ST_WALK;
    end
  end

  // State and result registers; reset drops any walk in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      depth_q <= '0;
      sym_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
    end
  end

  assign bus.Shift_En_O   = shift_en;
  assign bus.Table_En_O   = table_en;
  assign bus.Table_Addr_O = addr_d;
  assign bus.Valid_O      = (state_q == ST_DONE);
  assign bus.Error_O      = (state_q == ST_ERR);
  assign bus.Busy_O       = (state_q != ST_IDLE);
  assign bus.Symbol_O     = sym_q;
  assign bus.Length_O     = len_q;

endmodule

// File: tb/tb_vlc_table_walker.sv
// Directed bench for vlc_table_walker with a 1-cycle-latency ROM holding three small trees.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercised through Data_Valid_I stalls and delayed Ack_I.
module tb_vlc_table_walker;
  import vlc_pkg::*;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  logic [15:0] rom [0:1023];
  logic [15:0] rom_q;

  vlc_table_walker_if #(.ADDR_W(10), .NODE_W(8), .SEL_W(2), .LEN_W(5)) bus ();

  vlc_table_walker #(
    .ADDR_W     (10),
    .NODE_W     (8),
    .NUM_TABLES (4),
    .SEL_W      (2),
    .TABLE_BASE ({TABLE_B3_START, TABLE_B2_START, TABLE_B1_START, TABLE_B0_START}),
    .MAX_LEN    (16),
    .LEN_W      (5)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (bus.Table_En_O) rom_q <= rom[bus.Table_Addr_O];
  assign bus.Table_Data_I = rom_q;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.Start_I = 0; bus.Table_Sel_I = 0; bus.Data_In_I = 0; bus.Data_Valid_I = 0; bus.Ack_I = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle_inputs();
    smp();
    if (bus.Valid_O !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", bus.Valid_O); end n_cmp++;
    if (bus.Error_O !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %0b want 0", bus.Error_O); end n_cmp++;
    if (bus.Busy_O !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", bus.Busy_O); end n_cmp++;
    if (bus.Table_En_O !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %0b want 0", bus.Table_En_O); end n_cmp++;
    if (bus.Table_Addr_O !== 10'h000) begin n_bad++; $display("FAIL rst_addr: got %h want 000", bus.Table_Addr_O); end n_cmp++;
    if (bus.Symbol_O !== 7'h00 || bus.Length_O !== 5'd0) begin n_bad++; $display("FAIL rst_result: got sym %h len %0d want 0/0", bus.Symbol_O, bus.Length_O); end n_cmp++;
    nxt();
    resetn = 1;
    nxt();
  endtask

  // Code "1" in table 0 -> leaf 0x01, length 1.
  task automatic test_one_bit();
    bus.Start_I = 1; bus.Table_Sel_I = 0;
    smp();
    if (bus.Table_En_O !== 1'b1 || bus.Table_Addr_O !== 10'h000) begin n_bad++; $display("FAIL one_root: got en %0b addr %h want 1/000", bus.Table_En_O, bus.Table_Addr_O); end n_cmp++;
    if (bus.Shift_En_O !== 1'b0) begin n_bad++; $display("FAIL one_shift0: got %0b want 0", bus.Shift_En_O); end n_cmp++;
    nxt();
    bus.Start_I = 0; bus.Data_Valid_I = 1; bus.Data_In_I = 1;
    smp();
    if (bus.Shift_En_O !== 1'b1 || bus.Busy_O !== 1'b1) begin n_bad++; $display("FAIL one_shift1: got shift %0b busy %0b want 1/1", bus.Shift_En_O, bus.Busy_O); end n_cmp++;
    if (bus.Valid_O !== 1'b0) begin n_bad++; $display("FAIL one_early_valid: got %0b want 0", bus.Valid_O); end n_cmp++;
    nxt();
    bus.Data_Valid_I = 0; bus.Ack_I = 1;
    smp();
    if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h01 || bus.Length_O !== 5'd1) begin n_bad++; $display("FAIL one_result: got v %0b sym %h len %0d want 1/01/1", bus.Valid_O, bus.Symbol_O, bus.Length_O); end n_cmp++;
    if (bus.Shift_En_O !== 1'b0) begin n_bad++; $display("FAIL one_shift2: got %0b want 0", bus.Shift_En_O); end n_cmp++;
    nxt();
    bus.Ack_I = 0;
    smp();
    if (bus.Busy_O !== 1'b0 || bus.Valid_O !== 1'b0) begin n_bad++; $display("FAIL one_idle: got busy %0b valid %0b want 0/0", bus.Busy_O, bus.Valid_O); end n_cmp++;
    nxt();
  endtask

  // Table 1, code 0011 -> 0x2A; result held three cycles before Ack_I.
  task automatic test_table1();
    logic [3:0]  bits;
    logic [9:0]  exp_addr [0:3];
    bits = 4'b0011;
    exp_addr[0] = 10'h101; exp_addr[1] = 10'h102; exp_addr[2] = 10'h103; exp_addr[3] = 10'h000;
    bus.Start_I = 1; bus.Table_Sel_I = 1;
    smp();
    if (bus.Table_Addr_O !== 10'h100 || bus.Table_En_O !== 1'b1) begin n_bad++; $display("FAIL t1_root: got en %0b addr %h want 1/100", bus.Table_En_O, bus.Table_Addr_O); end n_cmp++;
    nxt();
    bus.Start_I = 0; bus.Data_Valid_I = 1;
    for (int i = 0; i < 4; i++) begin
      bus.Data_In_I = bits[3-i];
      smp();
      if (bus.Shift_En_O !== 1'b1) begin n_bad++; $display("FAIL t1_shift%0d: got %0b want 1", i, bus.Shift_En_O); end n_cmp++;
      if (i < 3 && bus.Table_Addr_O !== exp_addr[i]) begin n_bad++; $display("FAIL t1_addr%0d: got %h want %h", i, bus.Table_Addr_O, exp_addr[i]); end n_cmp++;
      nxt();
    end
    bus.Data_Valid_I = 0;
    for (int h = 0; h < 3; h++) begin
      bus.Ack_I = (h == 2);
      smp();
      if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h2A || bus.Length_O !== 5'd4) begin n_bad++; $display("FAIL t1_hold%0d: got v %0b sym %h len %0d want 1/2a/4", h, bus.Valid_O, bus.Symbol_O, bus.Length_O); end n_cmp++;
      nxt();
    end
    bus.Ack_I = 0;
    smp();
    if (bus.Valid_O !== 1'b0 || bus.Busy_O !== 1'b0) begin n_bad++; $display("FAIL t1_release: got v %0b busy %0b want 0/0", bus.Valid_O, bus.Busy_O); end n_cmp++;
    nxt();
  endtask

  // Same code with a two-cycle Data_Valid_I gap after the second bit.
  task automatic test_stall();
    logic       dv  [0:5];
    logic       din [0:5];
    logic [9:0] adr [0:5];
    dv[0]=1; din[0]=0; adr[0]=10'h101;
    dv[1]=1; din[1]=0; adr[1]=10'h102;
    dv[2]=0; din[2]=1; adr[2]=10'h102;
    dv[3]=0; din[3]=0; adr[3]=10'h102;
    dv[4]=1; din[4]=1; adr[4]=10'h103;
    dv[5]=1; din[5]=1; adr[5]=10'h000;
    bus.Start_I = 1; bus.Table_Sel_I = 1;
    nxt();
    bus.Start_I = 0;
    for (int i = 0; i < 6; i++) begin
      bus.Data_Valid_I = dv[i]; bus.Data_In_I = din[i];
      smp();
      if (bus.Shift_En_O !== dv[i]) begin n_bad++; $display("FAIL st_shift%0d: got %0b want %0b", i, bus.Shift_En_O, dv[i]); end n_cmp++;
      if (i < 5 && (bus.Table_Addr_O !== adr[i] || bus.Table_En_O !== 1'b1)) begin n_bad++; $display("FAIL st_addr%0d: got en %0b addr %h want 1/%h", i, bus.Table_En_O, bus.Table_Addr_O, adr[i]); end n_cmp++;
      if (bus.Valid_O !== 1'b0) begin n_bad++; $display("FAIL st_early%0d: got %0b want 0", i, bus.Valid_O); end n_cmp++;
      nxt();
    end
    bus.Data_Valid_I = 0; bus.Ack_I = 1;
    smp();
    if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h2A || bus.Length_O !== 5'd4) begin n_bad++; $display("FAIL st_result: got v %0b sym %h len %0d want 1/2a/4", bus.Valid_O, bus.Symbol_O, bus.Length_O); end n_cmp++;
    nxt();
    bus.Ack_I = 0;
  endtask

  // Table 2 is all internal nodes: error after the 16th shifted bit.
  task automatic test_error();
    bus.Start_I = 1; bus.Table_Sel_I = 2;
    smp();
    if (bus.Table_Addr_O !== 10'h200) begin n_bad++; $display("FAIL er_root: got %h want 200", bus.Table_Addr_O); end n_cmp++;
    nxt();
    bus.Start_I = 0; bus.Data_Valid_I = 1;
    for (int i = 1; i <= 16; i++) begin
      bus.Data_In_I = i[0];
      smp();
      if (bus.Shift_En_O !== 1'b1 || bus.Error_O !== 1'b0 || bus.Valid_O !== 1'b0) begin n_bad++; $display("FAIL er_bit%0d: got shift %0b err %0b v %0b want 1/0/0", i, bus.Shift_En_O, bus.Error_O, bus.Valid_O); end n_cmp++;
      nxt();
    end
    smp();
    if (bus.Error_O !== 1'b1 || bus.Valid_O !== 1'b0 || bus.Shift_En_O !== 1'b0) begin n_bad++; $display("FAIL er_flag: got err %0b v %0b shift %0b want 1/0/0", bus.Error_O, bus.Valid_O, bus.Shift_En_O); end n_cmp++;
    nxt();
    bus.Ack_I = 1;
    smp();
    if (bus.Error_O !== 1'b1) begin n_bad++; $display("FAIL er_hold: got %0b want 1", bus.Error_O); end n_cmp++;
    nxt();
    bus.Ack_I = 0; bus.Data_Valid_I = 0;
    smp();
    if (bus.Error_O !== 1'b0 || bus.Busy_O !== 1'b0) begin n_bad++; $display("FAIL er_clear: got err %0b busy %0b want 0/0", bus.Error_O, bus.Busy_O); end n_cmp++;
    nxt();
  endtask

  // Restart after two bits of a longer code, then decode the 1-bit code.
  task automatic test_abort();
    bus.Start_I = 1; bus.Table_Sel_I = 0;
    nxt();
    bus.Start_I = 0; bus.Data_Valid_I = 1; bus.Data_In_I = 0;
    nxt();
    nxt();
    bus.Start_I = 1; bus.Data_In_I = 1;
    smp();
    if (bus.Shift_En_O !== 1'b0 || bus.Table_Addr_O !== 10'h000 || bus.Table_En_O !== 1'b1) begin n_bad++; $display("FAIL ab_restart: got shift %0b en %0b addr %h want 0/1/000", bus.Shift_En_O, bus.Table_En_O, bus.Table_Addr_O); end n_cmp++;
    nxt();
    bus.Start_I = 0;
    smp();
    if (bus.Shift_En_O !== 1'b1) begin n_bad++; $display("FAIL ab_shift: got %0b want 1", bus.Shift_En_O); end n_cmp++;
    nxt();
    bus.Data_Valid_I = 0; bus.Ack_I = 1;
    smp();
    if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h01 || bus.Length_O !== 5'd1) begin n_bad++; $display("FAIL ab_result: got v %0b sym %h len %0d want 1/01/1", bus.Valid_O, bus.Symbol_O, bus.Length_O); end n_cmp++;
    nxt();
    bus.Ack_I = 0;
  endtask

  // Ack_I+Start_I in DONE chains the next decode; a lone Start_I in DONE is ignored.
  task automatic test_back_to_back();
    bus.Start_I = 1; bus.Table_Sel_I = 0;
    nxt();
    bus.Start_I = 0; bus.Data_Valid_I = 1; bus.Data_In_I = 1;
    nxt();
    bus.Start_I = 1; bus.Ack_I = 1; bus.Table_Sel_I = 1;
    smp();
    if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h01) begin n_bad++; $display("FAIL bb_first: got v %0b sym %h want 1/01", bus.Valid_O, bus.Symbol_O); end n_cmp++;
    if (bus.Table_Addr_O !== 10'h100 || bus.Table_En_O !== 1'b1 || bus.Shift_En_O !== 1'b0) begin n_bad++; $display("FAIL bb_root: got en %0b addr %h shift %0b want 1/100/0", bus.Table_En_O, bus.Table_Addr_O, bus.Shift_En_O); end n_cmp++;
    nxt();
    bus.Start_I = 0; bus.Ack_I = 0;
    smp();
    if (bus.Shift_En_O !== 1'b1 || bus.Valid_O !== 1'b0 || bus.Busy_O !== 1'b1) begin n_bad++; $display("FAIL bb_walk: got shift %0b v %0b busy %0b want 1/0/1", bus.Shift_En_O, bus.Valid_O, bus.Busy_O); end n_cmp++;
    nxt();
    bus.Start_I = 1; bus.Table_Sel_I = 0;
    smp();
    if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h11 || bus.Length_O !== 5'd1) begin n_bad++; $display("FAIL bb_second: got v %0b sym %h len %0d want 1/11/1", bus.Valid_O, bus.Symbol_O, bus.Length_O); end n_cmp++;
    if (bus.Table_En_O !== 1'b0 || bus.Shift_En_O !== 1'b0) begin n_bad++; $display("FAIL bb_ignore: got en %0b shift %0b want 0/0", bus.Table_En_O, bus.Shift_En_O); end n_cmp++;
    nxt();
    bus.Start_I = 0; bus.Ack_I = 1;
    smp();
    if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h11) begin n_bad++; $display("FAIL bb_held: got v %0b sym %h want 1/11", bus.Valid_O, bus.Symbol_O); end n_cmp++;
    nxt();
    bus.Ack_I = 0; bus.Data_Valid_I = 0;
    smp();
    if (bus.Busy_O !== 1'b0) begin n_bad++; $display("FAIL bb_idle: got %0b want 0", bus.Busy_O); end n_cmp++;
    nxt();
  endtask

  // Reset mid-walk clears everything; a following decode works normally.
  task automatic test_reset_midwalk();
    bus.Start_I = 1; bus.Table_Sel_I = 1;
    nxt();
    bus.Start_I = 0; bus.Data_Valid_I = 1; bus.Data_In_I = 0;
    nxt();
    smp();
    resetn = 0;
    #1;
    if (bus.Busy_O !== 1'b0 || bus.Valid_O !== 1'b0 || bus.Error_O !== 1'b0) begin n_bad++; $display("FAIL rm_state: got busy %0b v %0b err %0b want 0/0/0", bus.Busy_O, bus.Valid_O, bus.Error_O); end n_cmp++;
    if (bus.Shift_En_O !== 1'b0 || bus.Table_En_O !== 1'b0 || bus.Table_Addr_O !== 10'h000) begin n_bad++; $display("FAIL rm_rom: got shift %0b en %0b addr %h want 0/0/000", bus.Shift_En_O, bus.Table_En_O, bus.Table_Addr_O); end n_cmp++;
    nxt();
    smp();
    if (bus.Valid_O !== 1'b0 || bus.Error_O !== 1'b0) begin n_bad++; $display("FAIL rm_noresult: got v %0b err %0b want 0/0", bus.Valid_O, bus.Error_O); end n_cmp++;
    nxt();
    resetn = 1;
    idle_inputs();
    nxt();
    bus.Start_I = 1; bus.Table_Sel_I = 0;
    nxt();
    bus.Start_I = 0; bus.Data_Valid_I = 1; bus.Data_In_I = 1;
    nxt();
    bus.Data_Valid_I = 0; bus.Ack_I = 1;
    smp();
    if (bus.Valid_O !== 1'b1 || bus.Symbol_O !== 7'h01 || bus.Length_O !== 5'd1) begin n_bad++; $display("FAIL rm_after: got v %0b sym %h len %0d want 1/01/1", bus.Valid_O, bus.Symbol_O, bus.Length_O); end n_cmp++;
    nxt();
    bus.Ack_I = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int a = 0; a < 1024; a++) rom[a] = 16'h0000;
    // Table 0: "1" -> 0x01, "01" -> 0x05, "000" -> 0x03, "001" -> 0x02.
    rom[10'h000] = {8'h81, 8'h01};
    rom[10'h001] = {8'h85, 8'h02};
    rom[10'h002] = {8'h82, 8'h83};
    // Table 1: "0011" -> 0x2A; side branches are leaves 0x11..0x14.
    rom[10'h100] = {8'h91, 8'h01};
    rom[10'h101] = {8'h92, 8'h02};
    rom[10'h102] = {8'h03, 8'h93};
    rom[10'h103] = {8'hAA, 8'h94};
    // Table 2 left all-zero: every entry points back to its own root.
    test_reset();
    test_one_bit();
    test_table1();
    test_stall();
    test_error();
    test_abort();
    test_back_to_back();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
